// File: rtl/vme_master_pkg.sv
// ---------------------------------------------------------------------------
// vme_master_pkg
// Shared definitions for the VME A16 master:
//   state_e              - master cycle FSM states
//   AM_A16_USER/SUPER    - A16 address-modifier codes
//   DEFAULT_TIMEOUT_CYC  - default DTACK/BERR wait limit (sysclk cycles)
//   DEFAULT_SETUP_CYC    - default address/AM setup time before AS falls
//   drives_as/drives_ds  - strobe decode helpers for a given state
// ---------------------------------------------------------------------------
package vme_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_STROBE   = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_RELEASE  = 3'd4
    } state_e;

    localparam logic [5:0] AM_A16_USER  = 6'h29;
    localparam logic [5:0] AM_A16_SUPER = 6'h2D;

    localparam int DEFAULT_TIMEOUT_CYC = 512;
    localparam int DEFAULT_SETUP_CYC   = 2;

    // AS is held low from the STROBE state until the responder answers.
    function automatic logic drives_as(input state_e s);
        return (s == ST_STROBE) || (s == ST_WAIT_ACK);
    endfunction

    // Data strobes are only low while we wait for the acknowledge.
    function automatic logic drives_ds(input state_e s);
        return (s == ST_WAIT_ACK);
    endfunction

endpackage : vme_master_pkg

// File: rtl/vme_bus_timer.sv
// ---------------------------------------------------------------------------
// vme_bus_timer
// Bus watchdog for the VME master. Counts clock cycles while en_i is high and
// flags expiry on the LIMIT-th counted cycle. Only instantiated when the
// VME_MASTER_TIMEOUT_EN macro is defined.
//
// Ports:
//   clk_i     in   clock (rising edge)
//   rst_i     in   asynchronous active-high reset
//   clear_i   in   synchronous clear of the count (has priority over en_i)
//   en_i      in   count enable
//   expire_o  out  high during the LIMIT-th enabled cycle
// ---------------------------------------------------------------------------
module vme_bus_timer #(
    parameter int LIMIT = 512
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CW'(LIMIT - 1))) begin
            // Saturate at the terminal count; the master leaves the waiting
            // states on expiry, which clears the count again.
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && !clear_i && (cnt_q == CW'(LIMIT - 1));

endmodule : vme_bus_timer

// File: rtl/vme_a16_master.sv
// ---------------------------------------------------------------------------
// vme_a16_master
// Single-word (D16) VME A16 bus master. A local request is latched in IDLE,
// address/AM are presented for SETUP_CYC cycles, AS then DS0/DS1 are asserted,
// and the master waits for the responder's DTACK or BERR (both synchronized
// through two flops). Strobes are released on the answer, and the cycle ends
// with a one-cycle O_DONE pulse once the responder has released DTACK/BERR.
//
// Optional feature: define VME_MASTER_TIMEOUT_EN to add a watchdog
// (vme_bus_timer) that aborts WAIT_ACK/RELEASE after TIMEOUT_CYC cycles and
// reports a bus error. Without it the master waits indefinitely.
//
// Parameters:
//   TIMEOUT_CYC  wait limit in clock cycles (watchdog builds only, >= 2)
//   SETUP_CYC    address/AM setup cycles before AS falls (>= 1)
//
// Ports:
//   I_CLK_32M       in   sole clock
//   I_VME_SYSRESET  in   asynchronous active-high reset
//   I_REQ           in   transfer request (sampled in IDLE only)
//   I_WE            in   1 = write, 0 = read
//   I_ADDR[15:1]    in   word address
//   I_AM            in   address modifier
//   I_WDATA         in   write data
//   O_BUSY          out  master not idle
//   O_DONE          out  one-cycle completion pulse
//   O_BERR          out  bus error/timeout status, valid with O_DONE
//   O_RDATA         out  last read data
//   O_VME_AS/DS0/DS1 out active-low strobes
//   O_VME_WR        out  VME WRITE* (0 = write)
//   O_VME_A[15:1], O_VME_LWORD, O_VME_AM  out  address phase
//   O_VME_D, O_VME_D_EN  out  write data and its drive enable
//   I_VME_D         in   read data
//   I_VME_DTACK, I_VME_BERR  in  active-low, asynchronous responder lines
// ---------------------------------------------------------------------------
module vme_a16_master
    import vme_master_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
    parameter int SETUP_CYC   = DEFAULT_SETUP_CYC
) (
    input  logic        I_CLK_32M,
    input  logic        I_VME_SYSRESET,
    input  logic        I_REQ,
    input  logic        I_WE,
    input  logic [15:1] I_ADDR,
    input  logic [5:0]  I_AM,
    input  logic [15:0] I_WDATA,
    output logic        O_BUSY,
    output logic        O_DONE,
    output logic        O_BERR,
    output logic [15:0] O_RDATA,
    output logic        O_VME_AS,
    output logic        O_VME_DS0,
    output logic        O_VME_DS1,
    output logic        O_VME_WR,
    output logic [15:1] O_VME_A,
    output logic        O_VME_LWORD,
    output logic [5:0]  O_VME_AM,
    output logic [15:0] O_VME_D,
    output logic        O_VME_D_EN,
    input  logic [15:0] I_VME_D,
    input  logic        I_VME_DTACK,
    input  logic        I_VME_BERR
);

    localparam int SCW = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;

    generate
        if (SETUP_CYC < 1 || TIMEOUT_CYC < 2) begin : g_param_check
            $error("vme_a16_master: SETUP_CYC must be >= 1 and TIMEOUT_CYC >= 2");
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Responder line synchronizers (idle level is 1)
    // -----------------------------------------------------------------------
    logic dtack_meta_q;
    logic dtack_sync_q;
    logic berr_meta_q;
    logic berr_sync_q;

    always_ff @(posedge I_CLK_32M or posedge I_VME_SYSRESET) begin
        if (I_VME_SYSRESET) begin
            dtack_meta_q <= 1'b1;
            dtack_sync_q <= 1'b1;
            berr_meta_q  <= 1'b1;
            berr_sync_q  <= 1'b1;
        end else begin
            dtack_meta_q <= I_VME_DTACK;
            dtack_sync_q <= dtack_meta_q;
            berr_meta_q  <= I_VME_BERR;
            berr_sync_q  <= berr_meta_q;
        end
    end

    // -----------------------------------------------------------------------
    // State, datapath and output registers
    // -----------------------------------------------------------------------
    state_e           state_q,     state_d;
    logic [SCW-1:0]   setup_cnt_q, setup_cnt_d;
    logic             we_q,        we_d;
    logic [15:1]      addr_q,      addr_d;
    logic [5:0]       am_q,        am_d;
    logic [15:0]      wdata_q,     wdata_d;
    logic [15:0]      rdata_q,     rdata_d;
    logic             err_q,       err_d;
    logic             done_q,      done_d;
    logic             berr_out_q,  berr_out_d;
    logic             as_q,        as_d;
    logic             ds_q,        ds_d;
    logic             den_q,       den_d;

    logic             timeout_hit;
    logic             resp_released;

    assign resp_released = dtack_sync_q && berr_sync_q;

    // -----------------------------------------------------------------------
    // Optional watchdog
    // -----------------------------------------------------------------------
`ifdef VME_MASTER_TIMEOUT_EN
    logic waiting;

    assign waiting = (state_q == ST_WAIT_ACK) || (state_q == ST_RELEASE);

    vme_bus_timer #(
        .LIMIT    (TIMEOUT_CYC)
    ) u_bus_timer (
        .clk_i    (I_CLK_32M),
        .rst_i    (I_VME_SYSRESET),
        .clear_i  (!waiting),
        .en_i     (waiting),
        .expire_o (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Process 1: registers (async reset releases all strobes immediately)
    // -----------------------------------------------------------------------
    always_ff @(posedge I_CLK_32M or posedge I_VME_SYSRESET) begin
        if (I_VME_SYSRESET) begin
            state_q     <= ST_IDLE;
            setup_cnt_q <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            am_q        <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            berr_out_q  <= 1'b0;
            as_q        <= 1'b1;
            ds_q        <= 1'b1;
            den_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            setup_cnt_q <= setup_cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            am_q        <= am_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            done_q      <= done_d;
            berr_out_q  <= berr_out_d;
            as_q        <= as_d;
            ds_q        <= ds_d;
            den_q       <= den_d;
        end
    end

    // -----------------------------------------------------------------------
    // Process 2: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        setup_cnt_d = setup_cnt_q;
        case (state_q)
            ST_IDLE: begin
                setup_cnt_d = '0;
                if (I_REQ) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (setup_cnt_q == SCW'(SETUP_CYC - 1)) begin
                    state_d = ST_STROBE;
                end else begin
                    setup_cnt_d = setup_cnt_q + 1'b1;
                end
            end
            ST_STROBE: begin
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                // A real responder answer takes precedence over a watchdog
                // expiry landing in the same cycle.
                if (!berr_sync_q || !dtack_sync_q) begin
                    state_d = ST_RELEASE;
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RELEASE: begin
                if (resp_released || timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Process 3: outputs and datapath
    // -----------------------------------------------------------------------
    always_comb begin
        we_d       = we_q;
        addr_d     = addr_q;
        am_d       = am_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        done_d     = 1'b0;
        berr_out_d = berr_out_q;

        case (state_q)
            ST_IDLE: begin
                if (I_REQ) begin
                    we_d    = I_WE;
                    addr_d  = I_ADDR;
                    am_d    = I_AM;
                    wdata_d = I_WDATA;
                    err_d   = 1'b0;
                end
            end
            ST_WAIT_ACK: begin
                if (!berr_sync_q) begin
                    // BERR wins over a simultaneous DTACK; read data is
                    // left untouched.
                    err_d = 1'b1;
                end else if (!dtack_sync_q) begin
                    // The responder holds data valid while DTACK is low, so
                    // by the time the synchronized DTACK arrives the bus has
                    // been stable for two cycles and can be sampled directly.
                    if (!we_q) begin
                        rdata_d = I_VME_D;
                    end
                end else if (timeout_hit) begin
                    err_d      = 1'b1;
                    done_d     = 1'b1;
                    berr_out_d = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (resp_released) begin
                    done_d     = 1'b1;
                    berr_out_d = err_q;
                end else if (timeout_hit) begin
                    done_d     = 1'b1;
                    berr_out_d = 1'b1;
                end
            end
            default: begin
            end
        endcase

        // Strobes and drive enable are registered from the next state so the
        // bus pins never glitch on state decode.
        as_d  = !drives_as(state_d);
        ds_d  = !drives_ds(state_d);
        den_d = we_d && (state_d != ST_IDLE);
    end

    assign O_BUSY      = (state_q != ST_IDLE);
    assign O_DONE      = done_q;
    assign O_BERR      = berr_out_q;
    assign O_RDATA     = rdata_q;
    assign O_VME_AS    = as_q;
    assign O_VME_DS0   = ds_q;
    assign O_VME_DS1   = ds_q;
    assign O_VME_WR    = ~we_q;
    assign O_VME_A     = addr_q;
    assign O_VME_LWORD = 1'b1;
    assign O_VME_AM    = am_q;
    assign O_VME_D     = wdata_q;
    assign O_VME_D_EN  = den_q;

endmodule : vme_a16_master

// File: doc/vme_a16_master.md
VME_A16_MASTER -- requirements
Module: vme_a16_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 512, meaning sysclk cycles waiting for DTACK/BERR before local bus error.
REQ-002 SHALL have parameter SETUP_CYC, default 2, meaning cycles address/AM held stable before AS falls.
REQ-003 SHALL have port I_CLK_32M  in  1  sole clock, all logic on its rising edge.
REQ-004 SHALL have port I_VME_SYSRESET  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port I_REQ  in  1  local transfer request, sampled in IDLE only.
REQ-006 SHALL have port I_WE  in  1  1 = VME write, 0 = VME read.
REQ-007 SHALL have port I_ADDR  in  15 ([15:1])  word address.
REQ-008 SHALL have port I_AM  in  6  address modifier to drive.
REQ-009 SHALL have port I_WDATA  in  16  write data.
REQ-010 SHALL have port O_BUSY  out  1  high whenever state is not IDLE.
REQ-011 SHALL have port O_DONE  out  1  one-cycle pulse at cycle end.
REQ-012 SHALL have port O_BERR  out  1  valid with O_DONE, 1 = bus error or timeout.
REQ-013 SHALL have port O_RDATA  out  16  read data, held until next read completes.
REQ-014 SHALL have ports O_VME_AS, O_VME_DS0, O_VME_DS1  out  1 each  active-low strobes.
REQ-015 SHALL have port O_VME_WR  out  1  VME WRITE line, 0 = write, 1 = read.
REQ-016 SHALL have ports O_VME_A  out  15 ([15:1]), O_VME_LWORD  out  1, O_VME_AM  out  6.
REQ-017 SHALL have ports O_VME_D  out  16, O_VME_D_EN  out  1  data drive enable; I_VME_D  in  16.
REQ-018 SHALL have ports I_VME_DTACK, I_VME_BERR  in  1 each  active-low, asynchronous to the clock.

Function
REQ-019 I_VME_DTACK and I_VME_BERR SHALL pass through two-flop synchronizers; the FSM SHALL use only the synchronized values.
REQ-020 FSM states SHALL be IDLE, SETUP, STROBE, WAIT_ACK, RELEASE.
REQ-021 IDLE with I_REQ=1 SHALL latch I_WE/I_ADDR/I_AM/I_WDATA, drive O_VME_A/AM/WR/LWORD=1 next cycle, and enter SETUP.
REQ-022 SETUP SHALL last SETUP_CYC cycles, then assert O_VME_AS=0 and enter STROBE.
REQ-023 STROBE SHALL last one cycle, then assert O_VME_DS0=O_VME_DS1=0 and enter WAIT_ACK; on writes O_VME_D_EN SHALL be 1 from SETUP through RELEASE.
REQ-024 WAIT_ACK on synchronized DTACK=0 SHALL capture I_VME_D into O_RDATA (reads only), deassert AS/DS, and enter RELEASE.
REQ-025 WAIT_ACK on synchronized BERR=0 SHALL deassert AS/DS, set error flag, and enter RELEASE; BERR SHALL win when BERR and DTACK are seen together.
REQ-026 RELEASE SHALL wait until synchronized DTACK=1 and BERR=1, then pulse O_DONE with O_BERR, and return to IDLE.
REQ-027 I_REQ asserted outside IDLE SHALL be ignored; back-to-back requests SHALL be accepted in the IDLE cycle after O_DONE.
REQ-028 Cycle latency (DTACK present immediately) SHALL be 1+SETUP_CYC+1+WAIT+2 sync+RELEASE cycles; no fixed upper bound without timeout.

Reset
REQ-029 Reset SHALL force IDLE, O_VME_AS/DS0/DS1=1, O_VME_WR=1, O_VME_D_EN=0, O_BUSY=0, O_DONE=0, O_BERR=0, O_RDATA=0, O_VME_A=0, O_VME_AM=0, synchronizers=1.
REQ-030 Reset mid-cycle SHALL release all strobes immediately (asynchronously) and SHALL NOT pulse O_DONE.

Configuration
REQ-031 With VME_MASTER_TIMEOUT_EN defined, WAIT_ACK and RELEASE SHALL count cycles; reaching TIMEOUT_CYC SHALL release strobes, set O_BERR, pulse O_DONE, and return to IDLE.
REQ-032 Without VME_MASTER_TIMEOUT_EN, no counter SHALL exist and WAIT_ACK/RELEASE SHALL wait indefinitely.

Structure
REQ-033 Package vme_master_pkg SHALL hold the state enum, AM constants (A16_USER=6'h29, A16_SUPER=6'h2D), and default TIMEOUT_CYC.
REQ-034 Sub-module vme_bus_timer (counter, clear, expire output) SHALL implement the timeout, instantiated only under VME_MASTER_TIMEOUT_EN.

Verification
REQ-035 Write 0x0005 to A=0x7CA6, AM=0x29, responder DTACK after 4 cycles -> D=0x0005 driven, WR=0, O_DONE pulse, O_BERR=0.
REQ-036 Read A=0x7CA4, responder returns 0xA800 -> O_RDATA=0xA800, O_BERR=0.
REQ-037 Read A=0x1234, no responder, macro on, TIMEOUT_CYC=16 -> strobes released, O_BERR=1 after 16 wait cycles.
REQ-038 BERR and DTACK asserted same cycle -> O_BERR=1, O_RDATA unchanged.
REQ-039 Reset asserted in WAIT_ACK -> AS/DS=1 same cycle, no O_DONE, next I_REQ serviced normally.
REQ-040 I_REQ held high continuously -> consecutive cycles, AS returns to 1 between each, DTACK seen released before next AS.
